// File: rtl/lcd_button_ctrl.sv
// Debounced push-button peripheral with Avalon-MM register access.
// Optional level interrupt enabled by defining LCD_BUTTON_CTRL_IRQ_EN.
module lcd_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        PRESS_LEVEL     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_port,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
`ifdef LCD_BUTTON_CTRL_IRQ_EN
    output logic [31:0] readdata,
    output logic        irq
`else
    output logic [31:0] readdata
`endif
);

    localparam int unsigned CW = 20;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_REL,
        CHK_PRESS,
        STABLE_PRS,
        CHK_REL
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_pressed;
    logic          w_press;
    logic          w_db;
    logic          r_edge;
    logic [15:0]   r_press_count;
    logic [31:0]   r_readdata;
    logic [31:0]   w_rd_mux;
    logic          w_wr_cnt_clr;
    logic          w_wr_edge_clr;
    logic          w_unused;

    assign w_unused = &{1'b0, writedata[31:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= ~PRESS_LEVEL;
            r_sync2 <= ~PRESS_LEVEL;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (r_sync2 == PRESS_LEVEL);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STABLE_REL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The check state already counts as the first stable sample, so the
    // incremented count is compared against DEBOUNCE_CYCLES-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press      = 1'b0;
        case (r_state)
            STABLE_REL: begin
                if (w_pressed) begin
                    w_state_next = CHK_PRESS;
                    w_cnt_next   = '0;
                end
            end
            CHK_PRESS: begin
                if (!w_pressed) begin
                    w_state_next = STABLE_REL;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_state_next = STABLE_PRS;
                    w_cnt_next   = '0;
                    w_press      = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            STABLE_PRS: begin
                if (!w_pressed) begin
                    w_state_next = CHK_REL;
                    w_cnt_next   = '0;
                end
            end
            CHK_REL: begin
                if (w_pressed) begin
                    w_state_next = STABLE_PRS;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_state_next = STABLE_REL;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = STABLE_REL;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_db = (r_state == STABLE_PRS) || (r_state == CHK_REL);

    assign w_wr_cnt_clr  = write && (address == 2'd1);
    assign w_wr_edge_clr = write && (address == 2'd3) && writedata[0];

    // A press landing on the same edge as a clear write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge        <= 1'b0;
            r_press_count <= '0;
        end else begin
            if (w_press)
                r_edge <= 1'b1;
            else if (w_wr_edge_clr)
                r_edge <= 1'b0;

            if (w_wr_cnt_clr)
                r_press_count <= w_press ? 16'd1 : 16'd0;
            else if (w_press)
                r_press_count <= r_press_count + 16'd1;
        end
    end

`ifdef LCD_BUTTON_CTRL_IRQ_EN
    logic r_irq_mask;
    logic r_irq;
    logic w_wr_mask;

    assign w_wr_mask = write && (address == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_mask)
                r_irq_mask <= writedata[0];
            r_irq <= r_edge & r_irq_mask;
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0: w_rd_mux = {31'b0, w_db};
            2'd1: w_rd_mux = {16'b0, r_press_count};
`ifdef LCD_BUTTON_CTRL_IRQ_EN
            2'd2: w_rd_mux = {31'b0, r_irq_mask};
`else
            2'd2: w_rd_mux = '0;
`endif
            2'd3: w_rd_mux = {31'b0, r_edge};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_readdata <= '0;
        else if (read)
            r_readdata <= w_rd_mux;
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_lcd_button_ctrl.sv
// Scoreboard bench for lcd_button_ctrl: behavioural model predicts each read
// response; a negedge monitor pops and compares readdata (and irq when enabled).
module tb_lcd_button_ctrl;

    localparam int unsigned D  = 4;
    localparam logic        PL = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_port = ~PL;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
`ifdef LCD_BUTTON_CTRL_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_button_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .PRESS_LEVEL(PL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_port(in_port),
        .address(address),
        .read(read),
        .write(write),
`ifdef LCD_BUTTON_CTRL_IRQ_EN
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
`else
        .writedata(writedata),
        .readdata(readdata)
`endif
    );

    // Reference model: the button level is accepted once the synchronised
    // line has disagreed with it for D consecutive cycles.
    logic        hist[$];
    logic        db_m = 1'b0;
    int unsigned run = 0;
    logic        edge_m = 1'b0;
    logic [15:0] cnt_m = '0;
    logic        mask_m = 1'b0;
    logic        irq_m = 1'b0;
    logic        rd_valid = 1'b0;
    logic        started = 1'b0;
    logic [31:0] exp_q[$];
    logic [1:0]  addr_q[$];

    always @(posedge clk) begin
        logic s;
        logic press;
        if (reset) begin
            hist     = '{~PL, ~PL};
            db_m     = 1'b0;
            run      = 0;
            edge_m   = 1'b0;
            cnt_m    = '0;
            mask_m   = 1'b0;
            irq_m    = 1'b0;
            rd_valid = 1'b0;
        end else begin
            rd_valid = read;
            if (read) begin
                case (address)
                    2'd0: exp_q.push_back({31'b0, db_m});
                    2'd1: exp_q.push_back({16'b0, cnt_m});
`ifdef LCD_BUTTON_CTRL_IRQ_EN
                    2'd2: exp_q.push_back({31'b0, mask_m});
`else
                    2'd2: exp_q.push_back(32'd0);
`endif
                    default: exp_q.push_back({31'b0, edge_m});
                endcase
                addr_q.push_back(address);
            end
            irq_m = edge_m & mask_m;
            s = hist.pop_front();
            hist.push_back(in_port);
            press = 1'b0;
            if ((s == PL) != db_m) run = run + 1;
            else run = 0;
            if (run == D) begin
                db_m  = ~db_m;
                run   = 0;
                press = db_m;
            end
            if (press) edge_m = 1'b1;
            else if (write && address == 2'd3 && writedata[0]) edge_m = 1'b0;
            if (write && address == 2'd1) cnt_m = press ? 16'd1 : 16'd0;
            else if (press) cnt_m = cnt_m + 16'd1;
`ifdef LCD_BUTTON_CTRL_IRQ_EN
            if (write && address == 2'd2) mask_m = writedata[0];
`endif
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        logic [1:0]  a;
        if (rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_noexp: readdata=%h with no expected entry", readdata);
            end else begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if (readdata !== e) begin
                    bad++;
                    $display("FAIL rd_addr%0d t=%0t: got %h expected %h", a, $time, readdata, e);
                end
            end
        end
`ifdef LCD_BUTTON_CTRL_IRQ_EN
        if (started) begin
            total++;
            if (irq !== irq_m) begin
                bad++;
                $display("FAIL irq t=%0t: got %b expected %b", $time, irq, irq_m);
            end
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] a);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic read_all();
        for (int unsigned a = 0; a < 4; a++) do_read(2'(a));
    endtask

    task automatic poll_db(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) do_read(2'd0);
    endtask

    task automatic check_reset_regs(input string tag);
        tick();
        total++;
        if (readdata !== 32'd0) begin
            bad++;
            $display("FAIL %s: readdata=%h expected 00000000", tag, readdata);
        end
    endtask

    initial begin
        int unsigned hold;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        started = 1'b1;
        check_reset_regs("reset_readdata");
        read_all();

        // Clean press: db visible 6 cycles after the line change
        in_port = PL;
        poll_db(10);
        read_all();
        in_port = ~PL;
        poll_db(10);
        read_all();

        // Short glitch rejected
        in_port = PL;
        repeat (3) tick();
        in_port = ~PL;
        poll_db(10);
        read_all();

        // Press coinciding with edge clear, then a plain clear
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        in_port = PL;
        repeat (5) tick();
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        in_port = ~PL;
        repeat (10) tick();
        do_write(2'd3, 32'h1);
        do_read(2'd3);

        // Press coinciding with count clear
        in_port = PL;
        repeat (5) tick();
        do_write(2'd1, 32'hDEAD_BEEF);
        do_read(2'd1);
        in_port = ~PL;
        repeat (10) tick();

        // Read and write same cycle returns the pre-write value
        address = 2'd1; writedata = '0; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        do_read(2'd1);

        // Counter wrap from 0xFFFF
        force dut.r_press_count = 16'hFFFF;
        tick();
        release dut.r_press_count;
        cnt_m = 16'hFFFF;
        do_read(2'd1);
        in_port = PL;
        repeat (10) tick();
        do_read(2'd1);
        in_port = ~PL;
        repeat (10) tick();

        // Mask register and interrupt path
        do_write(2'd2, 32'hFFFF_FFF1);
        do_read(2'd2);
        in_port = PL;
        repeat (10) tick();
        do_write(2'd2, 32'h0);
        do_read(2'd2);
        repeat (2) tick();
        do_write(2'd2, 32'h1);
        repeat (2) tick();
        do_write(2'd3, 32'h1);
        repeat (2) tick();
        in_port = ~PL;
        repeat (10) tick();
        read_all();

        // Reset during press check (third of four samples)
        in_port = PL;
        repeat (5) tick();
        reset   = 1'b1;
        in_port = ~PL;
        tick();
        reset = 1'b0;
        check_reset_regs("reset_midcheck");
        read_all();
        repeat (10) tick();
        read_all();

        // Randomised traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                in_port = $urandom_range(1, 0);
                hold = $urandom_range(9, 1);
            end
            hold--;
            read      = ($urandom_range(1, 0) == 1);
            write     = ($urandom_range(4, 0) == 0);
            address   = 2'($urandom_range(3, 0));
            writedata = $urandom;
            tick();
        end
        read = 1'b0;
        write = 1'b0;
        read_all();
        repeat (3) tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_leftover: %0d expected reads never returned", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
